// File: rtl/adder_pkg.sv
// Shared definitions for the adder wrappers: FSM encoding, default widths
// and the signed-overflow flag helper.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNTW  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic pos;
        logic neg;
    } ovf_flags_t;

    // Overflow is only possible when both operands share a sign and the sum does not.
    function automatic ovf_flags_t ovf_flags(input logic a_msb, input logic b_msb,
                                             input logic s_msb);
        ovf_flags_t f;
        f.pos = ~a_msb & ~b_msb & s_msb;
        f.neg = a_msb & b_msb & ~s_msb;
        return f;
    endfunction

endpackage

// File: rtl/CarryLookAheadAdder2.sv
// Carry-lookahead adder: 4-bit lookahead groups chained group to group.
// WIDTH must be a multiple of 4.
module CarryLookAheadAdder2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int NBLK = WIDTH / 4;

    logic [3:0] g;
    logic [3:0] p;
    logic       carry;
    logic       c1;
    logic       c2;
    logic       c3;

    // NOTE: every variable written in a combinational block gets a default
    // before any conditional or loop code, so no path can infer a latch.
    always_comb begin
        g     = '0;
        p     = '0;
        c1    = 1'b0;
        c2    = 1'b0;
        c3    = 1'b0;
        carry = Cin;
        S     = '0;
        for (int k = 0; k < NBLK; k++) begin
            g  = A[4*k +: 4] & B[4*k +: 4];
            p  = A[4*k +: 4] ^ B[4*k +: 4];
            c1 = g[0] | (p[0] & carry);
            c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
            c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
            S[4*k +: 4] = p ^ {c3, c2, c1, carry};
            carry = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]) | ((&p) & carry);
        end
        Cout = carry;
    end

endmodule

// File: rtl/adder_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or above the pointer,
// wrapping modulo NREQ. Purely combinational.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_valid
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_valid && req_valid[idx]) begin
                any_valid      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one carry-lookahead adder between NREQ requesters with round-robin
// arbitration; results carry the owner id and signed overflow flags.
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = DEFAULT_CNTW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       reqValid,
    output logic [NREQ-1:0]       reqReady,
    input  logic [NREQ*WIDTH-1:0] reqA,
    input  logic [NREQ*WIDTH-1:0] reqB,
    input  logic [NREQ-1:0]       reqCin,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [IDW-1:0]        rspId,
    output logic [WIDTH-1:0]      rspS,
    output logic                  rspCout,
    output logic                  rspPosOverflow,
    output logic                  rspNegOverflow,
    output logic [CNTW-1:0]       ovfCount,
    output logic                  busy
);

    state_e           state_q,    state_d;
    logic [IDW-1:0]   ptr_q,      ptr_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic             cin_q,      cin_d;
    logic [IDW-1:0]   id_q,       id_d;
    logic [WIDTH-1:0] rsp_s_q,    rsp_s_d;
    logic [IDW-1:0]   rsp_id_q,   rsp_id_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_pos_q,  rsp_pos_d;
    logic             rsp_neg_q,  rsp_neg_d;
    logic [CNTW-1:0]  ovf_cnt_q,  ovf_cnt_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             any_valid;
    logic [WIDTH-1:0] sum;
    logic             sum_cout;
    ovf_flags_t       flags;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req_valid (reqValid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    CarryLookAheadAdder2 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A    (a_q),
        .B    (b_q),
        .Cin  (cin_q),
        .S    (sum),
        .Cout (sum_cout)
    );

    assign flags = ovf_flags(a_q[WIDTH-1], b_q[WIDTH-1], sum[WIDTH-1]);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        id_d       = id_q;
        rsp_s_d    = rsp_s_q;
        rsp_id_d   = rsp_id_q;
        rsp_cout_d = rsp_cout_q;
        rsp_pos_d  = rsp_pos_q;
        rsp_neg_d  = rsp_neg_q;
        ovf_cnt_d  = ovf_cnt_q;
        reqReady   = '0;

        case (state_q)
            IDLE: begin
                reqReady = grant;
                if (any_valid) begin
                    a_d     = reqA[int'(grant_idx)*WIDTH +: WIDTH];
                    b_d     = reqB[int'(grant_idx)*WIDTH +: WIDTH];
                    cin_d   = reqCin[grant_idx];
                    id_d    = grant_idx;
                    ptr_d   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
                    state_d = CALC;
                end
            end
            CALC: begin
                rsp_s_d    = sum;
                rsp_id_d   = id_q;
                rsp_cout_d = sum_cout;
                rsp_pos_d  = flags.pos;
                rsp_neg_d  = flags.neg;
                // Saturate: hold at all-ones rather than wrapping to zero.
                if ((flags.pos || flags.neg) && (ovf_cnt_q != '1)) begin
                    ovf_cnt_d = ovf_cnt_q + CNTW'(1);
                end
                state_d = RESP;
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    // NOTE: operand registers are reset along with control; an aborted
    // operation then leaves no stale operands visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= '0;
            rsp_s_q    <= '0;
            rsp_id_q   <= '0;
            rsp_cout_q <= 1'b0;
            rsp_pos_q  <= 1'b0;
            rsp_neg_q  <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            id_q       <= id_d;
            rsp_s_q    <= rsp_s_d;
            rsp_id_q   <= rsp_id_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_pos_q  <= rsp_pos_d;
            rsp_neg_q  <= rsp_neg_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign rspValid       = (state_q == RESP);
    assign busy           = (state_q != IDLE);
    assign rspS           = rsp_s_q;
    assign rspId          = rsp_id_q;
    assign rspCout        = rsp_cout_q;
    assign rspPosOverflow = rsp_pos_q;
    assign rspNegOverflow = rsp_neg_q;
    assign ovfCount       = ovf_cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: transaction-level reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_adder_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int CNTW  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       reqValid;
    logic [NREQ-1:0]       reqReady;
    logic [NREQ*WIDTH-1:0] reqA;
    logic [NREQ*WIDTH-1:0] reqB;
    logic [NREQ-1:0]       reqCin;
    logic                  rspValid;
    logic                  rspReady;
    logic [IDW-1:0]        rspId;
    logic [WIDTH-1:0]      rspS;
    logic                  rspCout;
    logic                  rspPosOverflow;
    logic                  rspNegOverflow;
    logic [CNTW-1:0]       ovfCount;
    logic                  busy;

    logic [WIDTH-1:0] a_in [NREQ];
    logic [WIDTH-1:0] b_in [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        reqA = '0;
        reqB = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqA[i*WIDTH +: WIDTH] = a_in[i];
            reqB[i*WIDTH +: WIDTH] = b_in[i];
        end
    end

    adder_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW),
        .CNTW  (CNTW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqA           (reqA),
        .reqB           (reqB),
        .reqCin         (reqCin),
        .rspValid       (rspValid),
        .rspReady       (rspReady),
        .rspId          (rspId),
        .rspS           (rspS),
        .rspCout        (rspCout),
        .rspPosOverflow (rspPosOverflow),
        .rspNegOverflow (rspNegOverflow),
        .ovfCount       (ovfCount),
        .busy           (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             pos;
        logic             neg;
        int               id;
    } res_t;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int off = 0; off < NREQ; off++) begin
            if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        end
        return -1;
    endfunction

    // Unsigned sum gives S/Cout; the exact signed sum decides overflow.
    function automatic res_t model_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic cin, input int id);
        res_t        r;
        logic [63:0] u;
        longint      sgn;
        longint      smax;
        longint      smin;
        u      = 64'(a) + 64'(b) + 64'(cin);
        sgn    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        smax   = (longint'(1) << (WIDTH-1)) - 1;
        smin   = -(longint'(1) << (WIDTH-1));
        r.s    = u[WIDTH-1:0];
        r.cout = u[WIDTH];
        r.pos  = (sgn > smax);
        r.neg  = (sgn < smin);
        r.id   = id;
        return r;
    endfunction

    int   m_ptr;
    int   m_stage;   // 0 accepting, 1 computing, 2 result offered
    int   m_cnt;
    res_t m_pend;
    res_t m_rsp;
    int   m_g;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   = 0;
            m_stage = 0;
            m_cnt   = 0;
            m_rsp   = '{s: '0, cout: 1'b0, pos: 1'b0, neg: 1'b0, id: 0};
            m_pend  = m_rsp;
        end else begin
            case (m_stage)
                0: begin
                    m_g = rr_pick(reqValid, m_ptr);
                    if (m_g >= 0) begin
                        m_pend  = model_add(a_in[m_g], b_in[m_g], reqCin[m_g], m_g);
                        m_ptr   = (m_g + 1) % NREQ;
                        m_stage = 1;
                    end
                end
                1: begin
                    m_rsp = m_pend;
                    if ((m_rsp.pos || m_rsp.neg) && m_cnt < (1 << CNTW) - 1) m_cnt++;
                    m_stage = 2;
                end
                default: begin
                    if (rspReady) m_stage = 0;
                end
            endcase
        end
    end

    int              cmp_g;
    logic [NREQ-1:0] cmp_ready;

    always @(negedge clk) begin
        if (rst_n) begin
            cmp_g     = rr_pick(reqValid, m_ptr);
            cmp_ready = '0;
            if (m_stage == 0 && cmp_g >= 0) cmp_ready[cmp_g] = 1'b1;
            check("reqReady", reqReady, cmp_ready);
            check("rspValid", rspValid, m_stage == 2);
            check("busy", busy, m_stage != 0);
            check("ovfCount", ovfCount, m_cnt);
            check("rspS", rspS, m_rsp.s);
            check("rspCout", rspCout, m_rsp.cout);
            check("rspPosOverflow", rspPosOverflow, m_rsp.pos);
            check("rspNegOverflow", rspNegOverflow, m_rsp.neg);
            check("rspId", rspId, m_rsp.id);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        step();
        rst_n    = 1'b0;
        reqValid = '0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(output int lat, output res_t r);
        logic got;
        got = 1'b0;
        lat = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            lat++;
            if (rspValid) got = 1'b1;
        end
        check("rsp_arrives", got, 1'b1);
        r.s    = rspS;
        r.cout = rspCout;
        r.pos  = rspPosOverflow;
        r.neg  = rspNegOverflow;
        r.id   = int'(rspId);
    endtask

    task automatic do_op(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, output res_t r, output int lat);
        logic hs;
        step();
        a_in[idx]   = a;
        b_in[idx]   = b;
        reqCin[idx] = cin;
        reqValid    = NREQ'(1) << idx;
        hs          = 1'b0;
        for (int t = 0; t < 20 && !hs; t++) begin
            @(negedge clk);
            if (reqReady[idx]) hs = 1'b1;
        end
        check("req_handshake", hs, 1'b1);
        step();
        reqValid = '0;
        wait_rsp(lat, r);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    res_t r;
    int   lat;
    int   ids[$];
    int   cyc[$];
    int   exp_ids[5] = '{0, 1, 2, 3, 0};

    initial begin
        reqValid = '0;
        reqCin   = '0;
        rspReady = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end
        repeat (2) step();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_rspValid", rspValid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ovfCount", ovfCount, 4'h0);
        check("reset_reqReady", reqReady, 4'b0000);
        check("reset_rspS", rspS, 32'h0);

        // Single request: 5 + (-3)
        do_op(0, 32'd5, 32'hFFFF_FFFD, 1'b0, r, lat);
        check("single_latency", lat, 2);
        check("single_s", r.s, 32'd2);
        check("single_cout", r.cout, 1'b1);
        check("single_pos", r.pos, 1'b0);
        check("single_neg", r.neg, 1'b0);
        check("single_id", r.id, 0);

        // Round robin with all four requesters valid
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_in[i] = 32'(i * 16);
            b_in[i] = 32'(i);
        end
        rspReady = 1'b1;
        reqValid = '1;
        for (int t = 0; t < 100 && ids.size() < 5; t++) begin
            @(negedge clk);
            if (rspValid && rspReady) begin
                ids.push_back(int'(rspId));
                cyc.push_back(t);
            end
        end
        step();
        reqValid = '0;
        check("rr_count", ids.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < ids.size()) check("rr_order", ids[k], exp_ids[k]);
            if (k > 0 && k < cyc.size()) check("rr_interval", cyc[k] - cyc[k-1], 3);
        end

        // Positive then negative overflow
        apply_reset();
        do_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, r, lat);
        check("povf_s", r.s, 32'h8000_0000);
        check("povf_pos", r.pos, 1'b1);
        check("povf_neg", r.neg, 1'b0);
        check("povf_cout", r.cout, 1'b0);
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, lat);
        check("novf_s", r.s, 32'h7FFF_FFFF);
        check("novf_neg", r.neg, 1'b1);
        check("novf_pos", r.pos, 1'b0);
        check("novf_cout", r.cout, 1'b1);
        @(negedge clk);
        check("ovf_count_two", ovfCount, 4'd2);

        // Backpressure: response held while others wait
        rspReady = 1'b0;
        do_op(2, 32'd100, 32'd50, 1'b1, r, lat);
        check("bp_s", r.s, 32'd151);
        check("bp_id", r.id, 2);
        reqValid = 4'b1011;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_s", rspS, 32'd151);
            check("bp_hold_valid", rspValid, 1'b1);
            check("bp_hold_ready", reqReady, 4'b0000);
        end
        step();
        rspReady = 1'b1;
        reqValid = '0;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_busy", busy, 1'b0);
        check("bp_release_valid", rspValid, 1'b0);

        // Reset while computing; pointer was 3, then moves to 2 after this grant
        step();
        a_in[1]  = 32'h7FFF_FFFF;
        b_in[1]  = 32'h1;
        reqValid = 4'b0010;
        @(negedge clk);
        check("mid_grant", reqReady, 4'b0010);
        step();
        reqValid = '0;
        check("mid_busy_calc", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rspValid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ovf", ovfCount, 4'h0);
        check("mid_rst_ready", reqReady, 4'b0000);
        step();
        rst_n      = 1'b1;
        a_in[0]    = 32'd1;
        b_in[0]    = 32'd2;
        reqCin[0]  = 1'b0;
        a_in[2]    = 32'd9;
        reqValid   = 4'b0101;
        @(negedge clk);
        check("post_rst_grant", reqReady, 4'b0001);
        step();
        reqValid = '0;
        wait_rsp(lat, r);
        check("post_rst_id", r.id, 0);
        check("post_rst_s", r.s, 32'd3);
        step();

        // Counter saturation: 2^CNTW + 3 overflowing additions
        apply_reset();
        for (int k = 0; k < (1 << CNTW) + 3; k++) begin
            do_op(k % NREQ, 32'h7FFF_FFFF, 32'h1, 1'b0, r, lat);
            if (k == 13) check("sat_count_14", ovfCount, 4'hE);
            if (k == 14) check("sat_count_15", ovfCount, 4'hF);
        end
        check("sat_final", ovfCount, 4'hF);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 32-bit carry-lookahead adder datapath between NREQ requesters using round-robin arbitration.
- Each requester presents A, B and Cin with a valid/ready handshake. The block latches the winning operands, computes the sum, and returns S, Cout, posOverflow and negOverflow tagged with the requester id.
- Sits in front of the adder wherever several ALU/multiplier sequencers need occasional wide additions.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, id width; must equal clog2(NREQ).
- CNTW, 16, width of the saturating overflow event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqValid  in  NREQ  per-requester operand valid.
- reqReady  out  NREQ  per-requester accept; one-hot or zero.
- reqA  in  NREQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- reqB  in  NREQ*WIDTH  packed operand B, same packing as reqA.
- reqCin  in  NREQ  per-requester carry-in.
- rspValid  out  1  result valid.
- rspReady  in  1  consumer accepts result.
- rspId  out  IDW  index of the requester that owns the result.
- rspS  out  WIDTH  sum.
- rspCout  out  1  carry out of the MSB.
- rspPosOverflow  out  1  signed positive overflow.
- rspNegOverflow  out  1  signed negative overflow.
- ovfCount  out  CNTW  saturating count of results with either overflow flag set.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, any time):
  - state=IDLE and priority pointer=0.
  - rspValid=0, rspS=0, rspId=0, rspCout=0, both overflow flags=0.
  - ovfCount=0, busy=0, reqReady=0.
  - Any in-flight operation is dropped silently.
- FSM states are IDLE, CALC and RESP.
- IDLE:
  - reqReady[g]=1 only for the grant g, and only if some reqValid is high.
  - g is the first asserted reqValid found scanning from the pointer upward, wrapping modulo NREQ.
  - On handshake (reqValid[g]&&reqReady[g]), latch A, B, Cin and id=g; set pointer=(g+1) mod NREQ; go to CALC.
  - With no valid requests, stay in IDLE and leave the pointer unchanged.
- CALC:
  - The adder computes combinationally from the latched operands.
  - At the clock edge, register S, Cout and the flags into the rsp registers; go to RESP.
  - reqReady=0.
- RESP:
  - rspValid=1.
  - All rsp outputs are held stable until rspValid&&rspReady, then go to IDLE with rspValid=0 next cycle.
  - No request is accepted in the same cycle as the response handshake.
- Latency and throughput:
  - Request handshake at edge N gives rspValid=1 after edge N+1.
  - With rspReady held high, the minimum issue interval is 3 cycles.
- Arithmetic:
  - {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1).
  - posOverflow = ~A[MSB] & ~B[MSB] & S[MSB].
  - negOverflow = A[MSB] & B[MSB] & ~S[MSB].
  - The two flags are mutually exclusive.
- ovfCount:
  - Increments when a result with either flag set is registered (the CALC→RESP edge).
  - Saturates at all-ones; never wraps.
- Stability rule: reqValid may drop without a handshake, and no state changes in that case.
- Any X on reqValid is a bench error and is not handled.

Decomposition:
- Shared package adder_pkg holds:
  - the FSM state encoding constants (IDLE=2'd0, CALC=2'd1, RESP=2'd2);
  - the default WIDTH and CNTW;
  - the overflow-flag function used by all adder wrappers.
- One natural sub-module: rr_picker (combinational). It takes reqValid and the pointer, and returns a one-hot grant plus a grant index.
- The existing CarryLookAheadAdder2 is instantiated unchanged as the datapath.

Test Plan:
- Single request: reqValid=4'b0001, A=5, B=-3, Cin=0 → after 2 cycles rspValid=1, rspS=2, rspCout=1, both flags 0, rspId=0.
- Round robin: all four valid continuously, rspReady=1 → grants in order 0,1,2,3,0; each rspId matches; exactly one reqReady bit high per IDLE cycle.
- Overflow:
  - A=32'h7FFFFFFF, B=1 → rspS=32'h80000000, rspPosOverflow=1, rspCout=0.
  - Then A=32'h80000000, B=32'hFFFFFFFF → rspS=32'h7FFFFFFF, rspNegOverflow=1, rspCout=1.
  - ovfCount=2 after both.
- Backpressure: hold rspReady=0 for 5 cycles after a result with A=100, B=50, Cin=1 → rspS=151 stable; reqReady=0 throughout; release → IDLE next cycle.
- Reset mid-operation: drop rst_n while in CALC → rspValid, busy, ovfCount and the pointer clear immediately; after release, requester 0 wins over 2 when both are valid.
- Saturation: force 2^CNTW+3 overflowing additions (CNTW overridden to 4) → ovfCount stays at 4'hF.
